// File: rtl/integer_widen_unpack_pkg.sv
// integer_widen_unpack_pkg: shared defaults, state type and saturation-code helper for the widening unpacker
package integer_widen_unpack_pkg;
  localparam int DEF_IN_SIZE = 8;
  localparam int DEF_OUT_SIZE = 2;
  localparam int DEF_IN_WIDTH = 8;
  localparam int DEF_IN_FRAC_WIDTH = 4;
  localparam int DEF_OUT_WIDTH = 16;
  localparam int DEF_OUT_FRAC_WIDTH = 8;
  localparam int NUM_CHUNKS = DEF_IN_SIZE / DEF_OUT_SIZE;
  localparam int FRAC_SHIFT = DEF_OUT_FRAC_WIDTH - DEF_IN_FRAC_WIDTH;
  typedef enum logic {IDLE, BUSY} state_e;
  // neg=1 gives {1,0..0,1} (most negative code + 1), neg=0 gives {0,1..1}
  function automatic logic [63:0] sat_code(input int w, input logic neg);
    return neg ? ((64'd1 << (w - 1)) | 64'd1) : ((64'd1 << (w - 1)) - 64'd1);
  endfunction
endpackage

// File: rtl/integer_widen_lane.sv
// integer_widen_lane: exact single-element widen; sat_o flag exists only with INTEGER_WIDEN_UNPACK_SAT_COUNT_EN
module integer_widen_lane import integer_widen_unpack_pkg::*; #(
  parameter int IN_WIDTH = 8,
  parameter int OUT_WIDTH = 16,
  parameter int SHIFT = 4
) (
  input  logic [IN_WIDTH-1:0]  x_i,
  output logic [OUT_WIDTH-1:0] y_o
`ifdef INTEGER_WIDEN_UNPACK_SAT_COUNT_EN
  ,
  output logic                 sat_o
`endif
);
  assign y_o = OUT_WIDTH'($signed(x_i)) << SHIFT;
`ifdef INTEGER_WIDEN_UNPACK_SAT_COUNT_EN
  assign sat_o = (x_i == IN_WIDTH'(sat_code(IN_WIDTH, 1'b1))) || (x_i == IN_WIDTH'(sat_code(IN_WIDTH, 1'b0)));
`endif
endmodule

// File: rtl/integer_widen_unpack.sv
// integer_widen_unpack: widen a captured vector and stream it out as OUT_SIZE-lane chunks.
// Saturation-code flags and counter are built only with INTEGER_WIDEN_UNPACK_SAT_COUNT_EN.
module integer_widen_unpack import integer_widen_unpack_pkg::*; #(
  parameter int IN_SIZE = DEF_IN_SIZE,
  parameter int OUT_SIZE = DEF_OUT_SIZE,
  parameter int IN_WIDTH = DEF_IN_WIDTH,
  parameter int IN_FRAC_WIDTH = DEF_IN_FRAC_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH,
  parameter int OUT_FRAC_WIDTH = DEF_OUT_FRAC_WIDTH,
  parameter int SAT_COUNT_WIDTH = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [IN_SIZE-1:0][IN_WIDTH-1:0]    data_in,
  input  logic                                data_in_valid,
  output logic                                data_in_ready,
  output logic [OUT_SIZE-1:0][OUT_WIDTH-1:0]  data_out,
  output logic                                data_out_valid,
  input  logic                                data_out_ready,
  output logic                                data_out_last,
  output logic [OUT_SIZE-1:0]                 data_out_sat,
  output logic [SAT_COUNT_WIDTH-1:0]          sat_count
);
  localparam int NC = IN_SIZE / OUT_SIZE;
  localparam int FS = OUT_FRAC_WIDTH - IN_FRAC_WIDTH;
  localparam int IW = NC > 1 ? $clog2(NC) : 1;
  localparam logic [IW-1:0] LAST = IW'(NC - 1);
  state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [NC-1:0][OUT_SIZE-1:0][OUT_WIDTH-1:0] wide_q, wide_d;
  logic at_last, in_hs, out_hs;
  assign at_last = (NC == 1) || (idx_q == LAST);
  assign data_out_valid = state_q == BUSY;
  // the last chunk leaving frees the holding register in the same cycle
  assign data_in_ready = (state_q == IDLE) || (at_last && data_out_ready);
  assign in_hs = data_in_valid && data_in_ready;
  assign out_hs = data_out_valid && data_out_ready;
  assign data_out_last = data_out_valid && at_last;
  assign data_out = wide_q[idx_q];
`ifdef INTEGER_WIDEN_UNPACK_SAT_COUNT_EN
  localparam int SW = SAT_COUNT_WIDTH + $clog2(IN_SIZE + 1);
  logic [NC-1:0][OUT_SIZE-1:0] sat_q, sat_d;
  logic [SAT_COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [SW-1:0] sum;
`endif
  for (genvar g = 0; g < IN_SIZE; g++) begin : g_lane
    integer_widen_lane #(
      .IN_WIDTH(IN_WIDTH),
      .OUT_WIDTH(OUT_WIDTH),
      .SHIFT(FS)
    ) u_lane (
      .x_i(data_in[g]),
      .y_o(wide_d[g / OUT_SIZE][g % OUT_SIZE])
`ifdef INTEGER_WIDEN_UNPACK_SAT_COUNT_EN
      ,
      .sat_o(sat_d[g / OUT_SIZE][g % OUT_SIZE])
`endif
    );
  end
  always_comb begin
    state_d = in_hs ? BUSY : (out_hs && at_last) ? IDLE : state_q;
    idx_d = in_hs ? '0 : (out_hs && !at_last) ? idx_q + 1'b1 : idx_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      wide_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      if (in_hs) wide_q <= wide_d;
    end
  end
`ifdef INTEGER_WIDEN_UNPACK_SAT_COUNT_EN
  always_comb begin
    sum = SW'(cnt_q) + SW'($countones(sat_d));
    cnt_d = (|sum[SW-1:SAT_COUNT_WIDTH]) ? '1 : sum[SAT_COUNT_WIDTH-1:0];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_q <= '0;
      cnt_q <= '0;
    end else if (in_hs) begin
      sat_q <= sat_d;
      cnt_q <= cnt_d;
    end
  end
  assign data_out_sat = sat_q[idx_q];
  assign sat_count = cnt_q;
`else
  assign data_out_sat = '0;
  assign sat_count = '0;
`endif
endmodule

// File: tb/tb_integer_widen_unpack.sv
// tb_integer_widen_unpack: randomized and directed checks against a queue-based chunk model
module tb_integer_widen_unpack;
  localparam int IS = 8, OS = 2, NC = 4;
`ifdef INTEGER_WIDEN_UNPACK_SAT_COUNT_EN
  localparam bit SATEN = 1'b1;
`else
  localparam bit SATEN = 1'b0;
`endif
  typedef logic [IS-1:0][7:0] vec_t;
  typedef struct {
    logic [OS-1:0][15:0] d;
    logic [OS-1:0] s;
    logic last;
  } chunk_t;
  logic clk = 0, rst = 1;
  vec_t data_in = '0, data_in2 = '0;
  logic data_in_valid = 0, data_in_valid2 = 0, data_out_ready = 0, data_out_ready2 = 0;
  logic data_in_ready, data_out_valid, data_out_last, data_in_ready2, data_out_valid2, data_out_last2;
  logic [OS-1:0][15:0] data_out, data_out2;
  logic [OS-1:0] data_out_sat, data_out_sat2;
  logic [15:0] sat_count;
  logic [1:0] sat_count2;
  chunk_t q[$];
  int exp_cnt = 0;
  int checks = 0, errors = 0;

  integer_widen_unpack dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready), .data_out(data_out), .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready), .data_out_last(data_out_last),
    .data_out_sat(data_out_sat), .sat_count(sat_count)
  );
  integer_widen_unpack #(.SAT_COUNT_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .data_in(data_in2), .data_in_valid(data_in_valid2),
    .data_in_ready(data_in_ready2), .data_out(data_out2), .data_out_valid(data_out_valid2),
    .data_out_ready(data_out_ready2), .data_out_last(data_out_last2),
    .data_out_sat(data_out_sat2), .sat_count(sat_count2)
  );

  always #5 clk = ~clk;

  // reference: value v/16 re-expressed with 8 fractional bits is v*16
  function automatic void push_vec(input vec_t v);
    int n = 0;
    for (int k = 0; k < NC; k++) begin
      chunk_t c;
      for (int j = 0; j < OS; j++) begin
        int x = int'($signed(v[k*OS+j]));
        bit s = (x == 127) || (x == -127);
        c.d[j] = 16'(x * 16);
        c.s[j] = SATEN && s;
        n += int'(s);
      end
      c.last = (k == NC - 1);
      q.push_back(c);
    end
    exp_cnt = SATEN ? ((exp_cnt + n > 65535) ? 65535 : exp_cnt + n) : 0;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < IS; i++) begin
      int r = int'($urandom_range(0, 5));
      v[i] = r == 0 ? 8'h81 : r == 1 ? 8'h7F : 8'($urandom);
    end
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    data_in_valid = 0;
    data_in_valid2 = 0;
    data_out_ready = 0;
    data_out_ready2 = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    q.delete();
    exp_cnt = 0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (data_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", data_out_valid); end
    checks++; if (data_out_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b exp 0", data_out_last); end
    checks++; if (data_out_sat !== 2'b00) begin errors++; $display("FAIL reset_sat: got %b exp 00", data_out_sat); end
    checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL reset_data: got %h exp 0", data_out); end
    checks++; if (sat_count !== 16'h0) begin errors++; $display("FAIL reset_count: got %0d exp 0", sat_count); end
    @(negedge clk);
    #1;
    checks++; if (data_in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", data_in_ready); end
  endtask

  task automatic test_directed();
    vec_t v;
    logic [15:0] ed[8];
    logic [1:0] es[4];
    v = {8'h80, 8'hFF, 8'h01, 8'h81, 8'h7F, 8'h00, 8'hE8, 8'h18};
    ed = '{16'h0180, 16'hFE80, 16'h0000, 16'h07F0, 16'hF810, 16'h0010, 16'hFFF0, 16'hF800};
    es = '{2'b00, 2'b10 & {2{SATEN}}, 2'b01 & {2{SATEN}}, 2'b00};
    do_reset();
    for (int c = 0; c <= 13; c++) begin
      data_in = v;
      data_in_valid = (c <= 8);
      data_out_ready = 1;
      #1;
      if (c >= 1 && c <= 12) begin
        int k = (c - 1) % 4;
        int ec = SATEN ? 2 * (1 + (c - 1) / 4) : 0;
        checks++; if (data_out_valid !== 1'b1) begin errors++; $display("FAIL dir_valid c%0d: got %b exp 1", c, data_out_valid); end
        checks++; if (data_out !== {ed[2*k+1], ed[2*k]}) begin errors++; $display("FAIL dir_data c%0d: got %h exp %h", c, data_out, {ed[2*k+1], ed[2*k]}); end
        checks++; if (data_out_last !== (k == 3)) begin errors++; $display("FAIL dir_last c%0d: got %b exp %b", c, data_out_last, k == 3); end
        checks++; if (data_out_sat !== es[k]) begin errors++; $display("FAIL dir_sat c%0d: got %b exp %b", c, data_out_sat, es[k]); end
        checks++; if (data_in_ready !== (k == 3)) begin errors++; $display("FAIL dir_ready c%0d: got %b exp %b", c, data_in_ready, k == 3); end
        checks++; if (sat_count !== 16'(ec)) begin errors++; $display("FAIL dir_count c%0d: got %0d exp %0d", c, sat_count, ec); end
      end else if (c == 13) begin
        checks++; if (data_out_valid !== 1'b0) begin errors++; $display("FAIL dir_idle: got %b exp 0", data_out_valid); end
      end
      @(negedge clk);
    end
    data_in_valid = 0;
  endtask

  task automatic test_stall_toggle();
    do_reset();
    for (int cyc = 0; cyc < 200; cyc++) begin
      bit ev, er;
      data_out_ready = (cyc % 2 == 0);
      data_in_valid = $urandom_range(0, 3) != 0;
      data_in = rand_vec();
      #1;
      ev = q.size() > 0;
      er = q.size() == 0 || (q.size() == 1 && data_out_ready);
      checks++; if (data_out_valid !== ev) begin errors++; $display("FAIL stall_valid cyc%0d: got %b exp %b", cyc, data_out_valid, ev); end
      checks++; if (data_in_ready !== er) begin errors++; $display("FAIL stall_ready cyc%0d: got %b exp %b", cyc, data_in_ready, er); end
      checks++; if (sat_count !== 16'(exp_cnt)) begin errors++; $display("FAIL stall_count cyc%0d: got %0d exp %0d", cyc, sat_count, exp_cnt); end
      if (ev) begin
        checks++; if (data_out !== q[0].d) begin errors++; $display("FAIL stall_data cyc%0d: got %h exp %h", cyc, data_out, q[0].d); end
        checks++; if (data_out_last !== q[0].last) begin errors++; $display("FAIL stall_last cyc%0d: got %b exp %b", cyc, data_out_last, q[0].last); end
        checks++; if (data_out_sat !== q[0].s) begin errors++; $display("FAIL stall_sat cyc%0d: got %b exp %b", cyc, data_out_sat, q[0].s); end
      end
      if (ev && data_out_ready) void'(q.pop_front());
      if (data_in_valid && er) push_vec(data_in);
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    vec_t vs[2];
    int sent = 0, outs = 0, first = -1, lastc = -1;
    vs[0] = rand_vec();
    vs[1] = rand_vec();
    do_reset();
    for (int cyc = 0; cyc < 20; cyc++) begin
      bit ev, er;
      data_in_valid = sent < 2;
      data_in = vs[sent < 2 ? sent : 1];
      data_out_ready = 1;
      #1;
      ev = q.size() > 0;
      er = q.size() == 0 || q.size() == 1;
      checks++; if (data_out_valid !== ev) begin errors++; $display("FAIL b2b_valid cyc%0d: got %b exp %b", cyc, data_out_valid, ev); end
      checks++; if (data_in_ready !== er) begin errors++; $display("FAIL b2b_ready cyc%0d: got %b exp %b", cyc, data_in_ready, er); end
      if (ev) begin
        checks++; if (data_out !== q[0].d) begin errors++; $display("FAIL b2b_data cyc%0d: got %h exp %h", cyc, data_out, q[0].d); end
        void'(q.pop_front());
        outs++;
        if (first < 0) first = cyc;
        lastc = cyc;
      end
      if (data_in_valid && er) begin
        push_vec(data_in);
        sent++;
      end
      @(negedge clk);
    end
    data_in_valid = 0;
    checks++; if (outs != 8) begin errors++; $display("FAIL b2b_count: got %0d exp 8", outs); end
    checks++; if (lastc - first != 7) begin errors++; $display("FAIL b2b_span: got %0d exp 7", lastc - first); end
  endtask

  task automatic test_reset_mid();
    vec_t v = rand_vec();
    do_reset();
    data_in = v;
    data_in_valid = 1;
    data_out_ready = 1;
    @(negedge clk);
    data_in_valid = 0;
    push_vec(v);
    repeat (2) begin
      void'(q.pop_front());
      @(negedge clk);
    end
    data_out_ready = 0;
    #1;
    checks++; if (data_out !== q[0].d) begin errors++; $display("FAIL mid_chunk2: got %h exp %h", data_out, q[0].d); end
    #1 rst = 1;
    #1;
    checks++; if (data_out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b exp 0", data_out_valid); end
    checks++; if (sat_count !== 16'h0) begin errors++; $display("FAIL mid_count: got %0d exp 0", sat_count); end
    checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL mid_data: got %h exp 0", data_out); end
    @(negedge clk);
    rst = 0;
    q.delete();
    exp_cnt = 0;
    v = rand_vec();
    data_in = v;
    data_in_valid = 1;
    push_vec(v);
    @(negedge clk);
    data_in_valid = 0;
    #1;
    checks++; if (data_out_valid !== 1'b1) begin errors++; $display("FAIL mid_restart_valid: got %b exp 1", data_out_valid); end
    checks++; if (data_out !== q[0].d) begin errors++; $display("FAIL mid_restart_data: got %h exp %h", data_out, q[0].d); end
    checks++; if (sat_count !== 16'(exp_cnt)) begin errors++; $display("FAIL mid_restart_count: got %0d exp %0d", sat_count, exp_cnt); end
  endtask

  task automatic test_sat_saturate();
    do_reset();
    data_out_ready2 = 1;
    for (int c = 0; c <= 13; c++) begin
      vec_t u = {IS{8'h10}};
      u[c % IS] = 8'h81;
      data_in2 = u;
      data_in_valid2 = (c <= 12);
      #1;
      if (c % 4 == 1) begin
        int n = (c - 1) / 4 + 1;
        int e = SATEN ? (n > 3 ? 3 : n) : 0;
        checks++; if (sat_count2 !== 2'(e)) begin errors++; $display("FAIL satcap c%0d: got %0d exp %0d", c, sat_count2, e); end
      end
      @(negedge clk);
    end
    data_in_valid2 = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_stall_toggle();
    test_back_to_back();
    test_reset_mid();
    test_sat_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
